// File: rtl/rv_pkg.sv
// Shared definitions for the data-memory path.
//   F3_*       funct3 access-size codes (bits [1:0] = log2 bytes, bit 2 = unsigned load)
//   NUM_LANES  byte lanes on the doubleword bus
//   state_t    load/store controller FSM states
//   req_t      access fields latched for the duration of a bus transfer
//   misaligned helper: 1 when the byte offset is not a multiple of the access size
package rv_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LD  = 3'b011;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_LWU = 3'b110;
   localparam logic [2:0] F3_ILL = 3'b111;

   localparam int NUM_LANES = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic [2:0] off;   // byte offset within the doubleword
      logic [1:0] size;  // log2 of access bytes
      logic       uns;   // zero-extend loads
      logic       we;    // store
   } req_t;

   function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
      case (size)
         2'd1:    return off[0];
         2'd2:    return |off[1:0];
         2'd3:    return |off;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/dmem_lane.sv
// Combinational byte-lane steering for the doubleword bus.
//   Store side: st_size/st_off/st_data -> st_lane_data (data replicated into
//               every lane of its size) and st_strb (byte enables).
//   Load side:  ld_size/ld_uns/ld_off/ld_bus -> ld_data (lane selected,
//               shifted to bit 0, then sign- or zero-extended).
module dmem_lane
   import rv_pkg::*;
(
   input  logic [1:0]  st_size,
   input  logic [2:0]  st_off,
   input  logic [63:0] st_data,
   output logic [63:0] st_lane_data,
   output logic [7:0]  st_strb,
   input  logic [1:0]  ld_size,
   input  logic        ld_uns,
   input  logic [2:0]  ld_off,
   input  logic [63:0] ld_bus,
   output logic [63:0] ld_data
);

   // mask = access bytes - 1; low offset bits under the mask select the byte
   // within the access, the rest select which aligned slot it occupies
   logic [2:0] mask;
   assign mask = 3'((4'd1 << st_size) - 4'd1);

   logic [NUM_LANES-1:0][7:0] src, dst;
   assign src = st_data;

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      localparam logic [2:0] IDX = 3'(i);
      assign dst[i]     = src[IDX & mask];
      assign st_strb[i] = ((IDX ^ st_off) & ~mask) == 3'd0;
   end

   assign st_lane_data = dst;

   logic [63:0] lane;
   logic        sx;
   assign lane = ld_bus >> {ld_off, 3'b000};

   always_comb begin
      ld_data = lane;
      sx      = 1'b0;
      case (ld_size)
         2'd0: begin
            sx      = ~ld_uns & lane[7];
            ld_data = {{56{sx}}, lane[7:0]};
         end
         2'd1: begin
            sx      = ~ld_uns & lane[15];
            ld_data = {{48{sx}}, lane[15:0]};
         end
         2'd2: begin
            sx      = ~ld_uns & lane[31];
            ld_data = {{32{sx}}, lane[31:0]};
         end
         default: ld_data = lane;
      endcase
   end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory load/store controller between the single-cycle datapath and a
// 64-bit req/ack bus. Holds the core via stall while an access is in flight.
//   clk, reset          clock, asynchronous active-high reset
//   mem_read/mem_write  level requests from control (held while stall=1)
//   funct3, addr, wdata access size, byte address, store data
//   rdata               extended load result (stable until the next load)
//   stall               hold pc / register write
//   err                 one-cycle pulse: misaligned, illegal size, bus error, timeout
//   bus_*               doubleword bus; bus_err/bus_rdata qualified by bus_ack
module dmem_ctrl
   import rv_pkg::*;
#(
   parameter int TIMEOUT = 255
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  funct3,
   input  logic [63:0] addr,
   input  logic [63:0] wdata,
   output logic [63:0] rdata,
   output logic        stall,
   output logic        err,
   output logic        bus_req,
   output logic        bus_we,
   output logic [63:0] bus_addr,
   output logic [63:0] bus_wdata,
   output logic [7:0]  bus_wstrb,
   input  logic        bus_ack,
   input  logic        bus_err,
   input  logic [63:0] bus_rdata
);

   localparam int CW = $clog2(TIMEOUT + 1);

   state_t        state, state_nx;
   req_t          req;
   logic [CW-1:0] cnt;
   logic          access, illegal, start, reject, timeout;
   logic [63:0]   st_lane_data, ld_data;
   logic [7:0]    st_strb;

   assign access  = mem_read | mem_write;
   assign illegal = (funct3 == F3_ILL) | misaligned(funct3[1:0], addr[2:0]);
   // cnt counts completed BUSY cycles, so the last allowed cycle sees TIMEOUT-1
   assign timeout = (cnt == CW'(TIMEOUT - 1));

   // Store steering uses the live request (registered on entry to BUSY);
   // load extraction uses the latched offset/size when the ack arrives.
   dmem_lane u_lane (
      .st_size      (funct3[1:0]),
      .st_off       (addr[2:0]),
      .st_data      (wdata),
      .st_lane_data (st_lane_data),
      .st_strb      (st_strb),
      .ld_size      (req.size),
      .ld_uns       (req.uns),
      .ld_off       (req.off),
      .ld_bus       (bus_rdata),
      .ld_data      (ld_data)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      stall    = 1'b0;
      start    = 1'b0;
      reject   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (access) begin
               stall = 1'b1;
               if (illegal) begin
                  reject   = 1'b1;
                  state_nx = ST_DONE;
               end else begin
                  start    = 1'b1;
                  state_nx = ST_BUSY;
               end
            end
         end
         ST_BUSY: begin
            stall = 1'b1;
            if (bus_ack || timeout) state_nx = ST_DONE;
         end
         // DONE retires the instruction; its still-asserted request is ignored
         ST_DONE: state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata     <= '0;
         err       <= 1'b0;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         bus_wstrb <= '0;
         cnt       <= '0;
         req       <= '0;
      end else begin
         err <= 1'b0;
         if (start) begin
            req.off   <= addr[2:0];
            req.size  <= funct3[1:0];
            req.uns   <= funct3[2];
            req.we    <= mem_write;
            bus_req   <= 1'b1;
            bus_we    <= mem_write;
            bus_addr  <= {addr[63:3], 3'b000};
            bus_wdata <= st_lane_data;
            bus_wstrb <= mem_write ? st_strb : 8'h00;
            cnt       <= '0;
         end
         if (reject) err <= 1'b1;
         if (state == ST_BUSY) begin
            if (bus_ack) begin
               if (!req.we) rdata <= ld_data;
               err       <= bus_err;
               bus_req   <= 1'b0;
               bus_we    <= 1'b0;
               bus_wstrb <= 8'h00;
            end else if (timeout) begin
               err       <= 1'b1;
               bus_req   <= 1'b0;
               bus_we    <= 1'b0;
               bus_wstrb <= 8'h00;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: transaction-level reference model with a
// per-cycle compare process, directed literal cases and randomized accesses.
module tb_dmem_ctrl;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_read, mem_write;
   logic [2:0]  funct3;
   logic [63:0] addr, wdata, rdata;
   logic        stall, err, bus_req, bus_we;
   logic [63:0] bus_addr, bus_wdata;
   logic [7:0]  bus_wstrb;
   logic        bus_ack, bus_err;
   logic [63:0] bus_rdata;

   int checks = 0;
   int errors = 0;

   dmem_ctrl #(.TIMEOUT(TO)) dut (
      .clk       (clk),
      .reset     (reset),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .funct3    (funct3),
      .addr      (addr),
      .wdata     (wdata),
      .rdata     (rdata),
      .stall     (stall),
      .err       (err),
      .bus_req   (bus_req),
      .bus_we    (bus_we),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_wstrb (bus_wstrb),
      .bus_ack   (bus_ack),
      .bus_err   (bus_err),
      .bus_rdata (bus_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [63:0] m_rdata;

   function automatic int nbytes(input logic [2:0] f3);
      return 1 << f3[1:0];
   endfunction

   function automatic logic legal(input logic [2:0] f3, input logic [63:0] a);
      if (f3 == 3'b111) return 1'b0;
      return (int'(a[2:0]) % nbytes(f3)) == 0;
   endfunction

   function automatic logic [7:0] m_strb(input logic [2:0] f3, input logic [63:0] a);
      logic [7:0] s = '0;
      for (int i = 0; i < nbytes(f3); i++) s[int'(a[2:0]) + i] = 1'b1;
      return s;
   endfunction

   function automatic logic [63:0] m_wdata(input logic [2:0] f3, input logic [63:0] wd);
      logic [63:0] r;
      for (int i = 0; i < 8; i++) r[8*i +: 8] = wd[8*(i % nbytes(f3)) +: 8];
      return r;
   endfunction

   function automatic logic [63:0] m_load(input logic [2:0] f3, input logic [63:0] a,
                                          input logic [63:0] rb);
      int          n = nbytes(f3);
      logic [63:0] v = rb >> (8 * int'(a[2:0]));
      logic [63:0] m;
      if (n < 8) begin
         m = (64'd1 << (8 * n)) - 64'd1;
         v = v & m;
         if (!f3[2] && v[8*n-1]) v = v | ~m;
      end
      return v;
   endfunction

   // ---------------- per-cycle expectations ----------------
   logic        e_on = 1'b0;
   logic        e_stall, e_req, e_err, e_we;
   logic [63:0] e_addr, e_wdata, e_rdata;
   logic [7:0]  e_strb;

   always @(negedge clk) begin
      if (e_on) begin
         chk("stall", stall, e_stall);
         chk("bus_req", bus_req, e_req);
         chk("err", err, e_err);
         chk("rdata", rdata, e_rdata);
         if (e_req) begin
            chk("bus_we", bus_we, e_we);
            chk("bus_addr", bus_addr, e_addr);
            chk("bus_wstrb", bus_wstrb, e_strb);
            if (e_we) chk("bus_wdata", bus_wdata, e_wdata);
         end
      end
   end

   // observation counters / captures for the directed literal checks
   int          n_stall, n_req, n_err;
   logic [63:0] cap_addr, cap_wdata;
   logic [7:0]  cap_strb;
   logic        cap_we;

   always @(negedge clk) begin
      if (stall) n_stall++;
      if (err)   n_err++;
      if (bus_req) begin
         n_req++;
         cap_addr  = bus_addr;
         cap_wdata = bus_wdata;
         cap_strb  = bus_wstrb;
         cap_we    = bus_we;
      end
   end

   task automatic clr_obs();
      n_stall = 0;
      n_req   = 0;
      n_err   = 0;
   endtask

   task automatic idle();
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0; bus_ack = 1'b0; bus_err = 1'b0;
      e_stall = 1'b0; e_req = 1'b0; e_err = 1'b0; e_rdata = m_rdata;
      @(negedge clk); #1;
   endtask

   // ack_at: BUSY cycle (1-based) in which bus_ack is driven; > TO means never
   task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [63:0] a, input logic [63:0] wd,
                         input int ack_at, input logic [63:0] rb, input logic be);
      int nb;
      @(posedge clk); #1;
      mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
      bus_ack = 1'b0; bus_err = 1'b0;
      e_stall = 1'b1; e_req = 1'b0; e_err = 1'b0; e_rdata = m_rdata;
      if (!legal(f3, a)) begin
         @(posedge clk); #1;
         e_stall = 1'b0; e_err = 1'b1;
      end else begin
         nb     = (ack_at <= TO) ? ack_at : TO;
         e_we   = wr;
         e_addr = {a[63:3], 3'b000};
         e_strb = wr ? m_strb(f3, a) : 8'h00;
         e_wdata = m_wdata(f3, wd);
         for (int c = 1; c <= nb; c++) begin
            @(posedge clk); #1;
            e_req = 1'b1; e_stall = 1'b1; e_err = 1'b0;
            bus_ack   = (c == ack_at);
            bus_err   = (c == ack_at) ? be : 1'b0;
            bus_rdata = (c == ack_at) ? rb : {$urandom, $urandom};
         end
         @(posedge clk); #1;
         bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = {$urandom, $urandom};
         e_req = 1'b0; e_stall = 1'b0;
         if (ack_at <= TO) begin
            e_err = be;
            if (!wr) m_rdata = m_load(f3, a, rb);
         end else begin
            e_err = 1'b1;
         end
         e_rdata = m_rdata;
      end
      // DONE cycle: request still held and must be ignored
      @(negedge clk); #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] a;
      logic [2:0]  f3, msk;
      int          r;

      reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = '0;
      addr = '0; wdata = '0; bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = '0;
      m_rdata = '0;
      repeat (2) @(negedge clk);
      chk("rst_rdata", rdata, 64'h0);
      chk("rst_err", err, 1'b0);
      chk("rst_bus_req", bus_req, 1'b0);
      chk("rst_bus_we", bus_we, 1'b0);
      chk("rst_bus_wstrb", bus_wstrb, 8'h00);
      chk("rst_stall", stall, 1'b0);
      reset = 1'b0;
      e_stall = 1'b0; e_req = 1'b0; e_err = 1'b0; e_rdata = '0;
      e_on = 1'b1;
      idle();

      // ld 0x10, ack in second BUSY cycle
      clr_obs();
      access(1, 0, 3'b011, 64'h10, '0, 2, 64'h1122334455667788, 0);
      chk("ld_rdata", rdata, 64'h1122334455667788);
      chk("ld_bus_addr", cap_addr, 64'h10);
      chk("ld_wstrb", cap_strb, 8'h00);
      chk("ld_stall_cycles", n_stall, 3);
      chk("ld_req_cycles", n_req, 2);

      // lb / lbu from byte 7
      access(1, 0, 3'b000, 64'h17, '0, 1, 64'h80_00000000000000, 0);
      chk("lb_rdata", rdata, 64'hFFFFFFFFFFFFFF80);
      access(1, 0, 3'b100, 64'h17, '0, 1, 64'h80_00000000000000, 0);
      chk("lbu_rdata", rdata, 64'h80);

      // sh 0x22
      access(0, 1, 3'b001, 64'h22, 64'hBEEF, 1, '0, 0);
      chk("sh_bus_addr", cap_addr, 64'h20);
      chk("sh_wstrb", cap_strb, 8'b00001100);
      chk("sh_wdata_lane", cap_wdata[31:16], 16'hBEEF);
      chk("sh_we", cap_we, 1'b1);

      // misaligned lw, illegal funct3
      clr_obs();
      access(1, 0, 3'b010, 64'h06, '0, 1, '0, 0);
      chk("mis_req_cycles", n_req, 0);
      chk("mis_err_pulses", n_err, 1);
      chk("mis_stall_cycles", n_stall, 1);
      clr_obs();
      access(1, 0, 3'b111, 64'h00, '0, 1, '0, 0);
      chk("ill_req_cycles", n_req, 0);
      chk("ill_err_pulses", n_err, 1);

      // timeout, then bus error on sd
      clr_obs();
      access(1, 0, 3'b011, 64'h48, '0, TO + 1, '0, 0);
      chk("to_req_cycles", n_req, TO);
      chk("to_err_pulses", n_err, 1);
      clr_obs();
      access(0, 1, 3'b011, 64'h50, 64'hCAFE, 1, '0, 1);
      chk("berr_err_pulses", n_err, 1);

      // randomized accesses
      for (int k = 0; k < 300; k++) begin
         if ($urandom_range(0, 7) == 0) idle();
         f3 = 3'($urandom_range(0, 7));
         a  = {$urandom, $urandom};
         if ($urandom_range(0, 2) != 0) begin
            msk = 3'(nbytes(f3) - 1);
            a[2:0] = a[2:0] & ~msk;
         end
         r = $urandom_range(0, 3);
         access(r != 1, r == 1 || r == 2, f3, a, {$urandom, $urandom},
                $urandom_range(1, TO + 1), {$urandom, $urandom},
                $urandom_range(0, 7) == 0);
      end

      // ensure a nonzero rdata before the mid-access reset
      access(1, 0, 3'b011, 64'h60, '0, 1, 64'h0123456789ABCDEF, 0);
      e_on = 1'b0;
      @(posedge clk); #1;
      mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b011; addr = 64'h68;
      @(posedge clk); #1;
      @(posedge clk); #3;
      reset = 1'b1; #1;
      chk("mid_rst_bus_req", bus_req, 1'b0);
      chk("mid_rst_rdata", rdata, 64'h0);
      mem_read = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      bus_ack = 1'b1; bus_rdata = 64'hDEADBEEFDEADBEEF;
      @(posedge clk); #1;
      bus_ack = 1'b0;
      @(negedge clk);
      chk("late_ack_rdata", rdata, 64'h0);
      chk("late_ack_err", err, 1'b0);
      chk("late_ack_bus_req", bus_req, 1'b0);
      chk("late_ack_stall", stall, 1'b0);
      m_rdata = '0;
      e_stall = 1'b0; e_req = 1'b0; e_err = 1'b0; e_rdata = '0;
      e_on = 1'b1;
      access(1, 0, 3'b110, 64'h74, '0, 2, 64'h89ABCDEF_00000000, 0);
      chk("post_rst_lwu", rdata, 64'h0000000089ABCDEF);
      idle();

      e_on = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
